// File: rtl/motor_pwm_drive.sv
// Two-channel motor PWM driver with period-aligned sampling,
// reversal dead period and emergency stop.
module motor_pwm_drive #(
    parameter int CLK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       estop,
    input  logic [4:0] duty_l,
    input  logic [4:0] duty_r,
    input  logic       dir_l,
    input  logic       dir_r,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l_out,
    output logic       dir_r_out,
    output logic       period_start
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          ps_q;
    logic          tick;
    logic          boundary;

    logic [4:0] duty_in [2];
    logic [1:0] dir_in;

    state_e     st_q  [2];
    state_e     st_d  [2];
    logic [4:0] act_q [2];
    logic [4:0] act_d [2];
    logic [1:0] dir_q, dir_d;
    logic [1:0] pwm_q, pwm_d;

    assign duty_in[0] = duty_l;
    assign duty_in[1] = duty_r;
    assign dir_in     = {dir_r, dir_l};

    assign tick     = (presc_q == PMAX);
    assign boundary = tick && (cnt_q == 5'd31);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 5'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ps_q    <= boundary;
        end
    end

    // FSM state register (both channels)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i] <= RUN;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    // Next state: estop wins over a coincident boundary
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i] = st_q[i];
            if (estop) begin
                st_d[i] = RUN;
            end else if (boundary) begin
                unique case (st_q[i])
                    RUN:  st_d[i] = (dir_in[i] == dir_q[i]) ? RUN : DEAD;
                    DEAD: st_d[i] = RUN;
                endcase
            end
        end
    end

    always_comb begin
        dir_d = dir_q;
        for (int i = 0; i < 2; i++) begin
            act_d[i] = act_q[i];
            pwm_d[i] = en && !estop && (cnt_q < act_q[i]);
            if (estop) begin
                act_d[i] = '0;
            end else if (boundary) begin
                unique case (st_q[i])
                    RUN: begin
                        act_d[i] = (dir_in[i] == dir_q[i]) ? duty_in[i] : '0;
                    end
                    DEAD: begin
                        act_d[i] = duty_in[i];
                        dir_d[i] = dir_in[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act_q[i] <= '0;
            end
            dir_q <= 2'b11;
            pwm_q <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                act_q[i] <= act_d[i];
            end
            dir_q <= dir_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_l        = pwm_q[0];
    assign pwm_r        = pwm_q[1];
    assign dir_l_out    = dir_q[0];
    assign dir_r_out    = dir_q[1];
    assign period_start = ps_q;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Bench for motor_pwm_drive: period vectors, corner sequences
// and a random run against a period-arithmetic model.
module tb_motor_pwm_drive;

    localparam int CD  = 4;
    localparam int PER = CD * 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       estop = 1'b0;
    logic [4:0] duty_l = '0;
    logic [4:0] duty_r = '0;
    logic       dir_l = 1'b1;
    logic       dir_r = 1'b1;
    logic       pwm_l, pwm_r, dir_l_out, dir_r_out, period_start;

    motor_pwm_drive #(.CLK_DIV(CD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .estop        (estop),
        .duty_l       (duty_l),
        .duty_r       (duty_r),
        .dir_l        (dir_l),
        .dir_r        (dir_r),
        .pwm_l        (pwm_l),
        .pwm_r        (pwm_r),
        .dir_l_out    (dir_l_out),
        .dir_r_out    (dir_r_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: clock index since reset gives counter and boundaries
    int mt;
    int mact [2];
    bit mdead [2];
    bit mdir [2];
    bit mpwm [2];
    bit mps;
    int mcnt;
    bit mbnd;
    int mdin;
    bit mrin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt = 0;
            mps = 1'b0;
            for (int c = 0; c < 2; c++) begin
                mact[c] = 0;
                mdead[c] = 1'b0;
                mdir[c] = 1'b1;
                mpwm[c] = 1'b0;
            end
        end else begin
            mcnt = (mt / CD) % 32;
            mbnd = (mt % PER) == PER - 1;
            for (int c = 0; c < 2; c++) begin
                mdin = (c == 0) ? int'(duty_l) : int'(duty_r);
                mrin = (c == 0) ? dir_l : dir_r;
                mpwm[c] = en && !estop && (mcnt < mact[c]);
                if (estop) begin
                    mact[c] = 0;
                    mdead[c] = 1'b0;
                end else if (mbnd) begin
                    if (mdead[c]) begin
                        mdead[c] = 1'b0;
                        mdir[c] = mrin;
                        mact[c] = mdin;
                    end else if (mrin == mdir[c]) begin
                        mact[c] = mdin;
                    end else begin
                        mdead[c] = 1'b1;
                        mact[c] = 0;
                    end
                end
            end
            mps = mbnd;
            mt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            check("m_pwm_l", pwm_l, mpwm[0]);
            check("m_pwm_r", pwm_r, mpwm[1]);
            check("m_dir_l", dir_l_out, mdir[0]);
            check("m_dir_r", dir_r_out, mdir[1]);
            check("m_ps", period_start, mps);
        end
    end

    task automatic wait_ps();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3 * PER && !seen; k++) begin
            @(negedge clk);
            if (period_start) seen = 1'b1;
        end
        if (!seen) check("ps_timeout", 0, 1);
    endtask

    task automatic count_window(output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int j = 0; j < PER; j++) begin
            if (j > 0) @(negedge clk);
            hl += int'(pwm_l);
            hr += int'(pwm_r);
        end
    endtask

    typedef struct {
        bit       en;
        bit [4:0] dl;
        bit       drl;
        bit [4:0] dr;
        bit       drr;
        int       hl;
        int       hr;
        bit       edl;
        bit       edr;
    } vec_t;

    vec_t vt [9];

    initial begin
        int hl, hr, n;
        bit hit;

        vt[0] = '{1, 8, 1, 0, 1, 32, 0, 1, 1};
        vt[1] = '{1, 16, 1, 31, 1, 64, 124, 1, 1};
        vt[2] = '{1, 16, 0, 31, 1, 0, 124, 1, 1};
        vt[3] = '{1, 16, 0, 31, 0, 64, 0, 0, 1};
        vt[4] = '{1, 5, 0, 3, 1, 20, 12, 0, 1};
        vt[5] = '{1, 10, 1, 10, 0, 0, 0, 0, 1};
        vt[6] = '{1, 10, 1, 10, 0, 40, 40, 1, 0};
        vt[7] = '{0, 10, 1, 10, 0, 0, 0, 1, 0};
        vt[8] = '{1, 10, 1, 10, 0, 40, 40, 1, 0};

        duty_l = 5'd8;
        repeat (3) @(negedge clk);
        check("rst_pwm_l", pwm_l, 0);
        check("rst_dir_l", dir_l_out, 1);
        check("rst_dir_r", dir_r_out, 1);
        check("rst_ps", period_start, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 9; i++) begin
            en = vt[i].en;
            duty_l = vt[i].dl;
            dir_l = vt[i].drl;
            duty_r = vt[i].dr;
            dir_r = vt[i].drr;
            wait_ps();
            count_window(hl, hr);
            check($sformatf("v%0d_high_l", i), hl, vt[i].hl);
            check($sformatf("v%0d_high_r", i), hr, vt[i].hr);
            check($sformatf("v%0d_dir_l", i), dir_l_out, vt[i].edl);
            check($sformatf("v%0d_dir_r", i), dir_r_out, vt[i].edr);
        end

        // estop mid-period, then resume only after a boundary
        duty_l = 5'd20;
        wait_ps();
        repeat (10) @(negedge clk);
        check("estop_pre", pwm_l, 1);
        estop = 1'b1;
        @(negedge clk);
        check("estop_next", pwm_l, 0);
        repeat (5) @(negedge clk);
        estop = 1'b0;
        n = 0;
        hit = 1'b0;
        for (int k = 0; k < 2 * PER && !hit; k++) begin
            @(negedge clk);
            if (period_start) hit = 1'b1;
            else n += int'(pwm_l);
        end
        check("estop_bnd_seen", hit, 1);
        check("estop_hold", n, 0);
        count_window(hl, hr);
        check("estop_resume", hl, 80);

        // duty change at counter 10 waits for the next period
        duty_l = 5'd4;
        wait_ps();
        hl = 0;
        for (int j = 0; j < PER; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 41) duty_l = 5'd24;
            hl += int'(pwm_l);
        end
        check("duty_mid", hl, 16);
        wait_ps();
        count_window(hl, hr);
        check("duty_next", hl, 96);

        // reset during a dead period
        duty_l = 5'd16;
        dir_l = 1'b0;
        duty_r = 5'd31;
        wait_ps();
        repeat (20) @(negedge clk);
        check("dead_pwm_l", pwm_l, 0);
        check("dead_dir_l", dir_l_out, 1);
        check("pre_rst_pwm_r", pwm_r, 1);
        check("pre_rst_dir_r", dir_r_out, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pwm_l", pwm_l, 0);
        check("arst_pwm_r", pwm_r, 0);
        check("arst_dir_l", dir_l_out, 1);
        check("arst_dir_r", dir_r_out, 1);
        check("arst_ps", period_start, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // random run, model checks every clock
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) duty_l = 5'($urandom);
            if ($urandom_range(0, 39) == 0) duty_r = 5'($urandom);
            if ($urandom_range(0, 149) == 0) dir_l = ~dir_l;
            if ($urandom_range(0, 149) == 0) dir_r = ~dir_r;
            if ($urandom_range(0, 299) == 0) en = ~en;
            if (!estop && $urandom_range(0, 199) == 0) estop = 1'b1;
            else if (estop && $urandom_range(0, 9) == 0) estop = 1'b0;
            if (k == 2500) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
